i2c_master_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares one I2C master FSM controller between NUM_REQ on-chip requesters.
- Latches the winning requester's command, drives the master's enable/rw/addr/data inputs, and tracks the master's ready handshake through one full transaction.
- Returns read data and a per-requester done pulse, with a timeout error if the master stalls.
- Sits between the command sources (FIFOs/CSR engines) and the I2C master.

---
 rtl/i2c_master_arbiter.sv | 153 +++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_arbiter
// Description : Round-robin arbiter and transaction sequencer sharing one
//               I2C master between NUM_REQ requesters. Latches the winning
//               command, walks the master's ready handshake through one
//               transaction, and returns done/err/read data. A per-transaction
//               timeout recovers from a stalled master.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic                 i2c_clock_in,
  input  logic                 i2c_reset_n_in,
  input  logic [NUM_REQ-1:0]   req_in,
  input  logic [NUM_REQ-1:0]   req_rw_in,
  input  logic [7*NUM_REQ-1:0] req_addr_in,
  input  logic [8*NUM_REQ-1:0] req_data_in,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic [NUM_REQ-1:0]   done_out,
  output logic                 err_out,
  output logic [7:0]           rdata_out,
  output logic                 busy_out,
  output logic                 m_enable_out,
  output logic                 m_rw_out,
  output logic [6:0]           m_addr_out,
  output logic [7:0]           m_data_out,
  input  logic                 m_ready_in,
  input  logic [7:0]           m_rdata_in
);

  localparam int             c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_IDX_W-1:0]  r_ptr;
  logic [c_IDX_W-1:0]  r_idx;
  logic [TO_W-1:0]     r_to_cnt;

  logic                w_any;
  logic [c_IDX_W-1:0]  w_sel;
  logic [c_IDX_W-1:0]  w_ptr_next;

  // (base + off) modulo NUM_REQ, with off < NUM_REQ
  function automatic logic [c_IDX_W-1:0] wrap_add(input logic [c_IDX_W-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return c_IDX_W'(s);
  endfunction

  // Round-robin pick: first requester set at or above the pointer, wrapping
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req_in[wrap_add(r_ptr, k)]) begin
        w_any = 1'b1;
        w_sel = wrap_add(r_ptr, k);
      end
    end
  end

  // Pointer moves to the requester just after the one that was served
  always_comb begin
    w_ptr_next = (r_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + c_IDX_W'(1);
  end

  // Sequencer: arbitration, master handshake, completion and timeout
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
    if (!i2c_reset_n_in) begin
      r_state      <= ARB;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_to_cnt     <= '0;
      grant_out    <= '0;
      done_out     <= '0;
      err_out      <= 1'b0;
      rdata_out    <= '0;
      busy_out     <= 1'b0;
      m_enable_out <= 1'b0;
      m_rw_out     <= 1'b0;
      m_addr_out   <= '0;
      m_data_out   <= '0;
    end else begin
      // done/err are single-cycle pulses
      done_out <= '0;
      err_out  <= 1'b0;
      if (r_state == ARB) begin
        if (w_any) begin
          grant_out  <= NUM_REQ'(1) << w_sel;
          r_idx      <= w_sel;
          m_rw_out   <= req_rw_in[w_sel];
          m_addr_out <= req_addr_in[7*int'(w_sel) +: 7];
          m_data_out <= req_data_in[8*int'(w_sel) +: 8];
          r_to_cnt   <= '0;
          busy_out   <= 1'b1;
          r_state    <= ISSUE;
        end
      end else if (r_to_cnt == c_TO_LAST) begin
        // Timeout wins over any ready transition seen on this edge
        done_out     <= grant_out;
        err_out      <= 1'b1;
        m_enable_out <= 1'b0;
        grant_out    <= '0;
        busy_out     <= 1'b0;
        r_ptr        <= w_ptr_next;
        r_state      <= ARB;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
        case (r_state)
          ISSUE: begin
            if (m_ready_in) begin
              m_enable_out <= 1'b1;
              r_state      <= WAIT_BUSY;
            end
          end
          WAIT_BUSY: begin
            // Dropping enable once the master leaves idle forces a STOP
            if (!m_ready_in) begin
              m_enable_out <= 1'b0;
              r_state      <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (m_ready_in) begin
              done_out  <= grant_out;
              if (m_rw_out) rdata_out <= m_rdata_in;
              grant_out <= '0;
              busy_out  <= 1'b0;
              r_ptr     <= w_ptr_next;
              r_state   <= ARB;
            end
          end
          default: r_state <= ARB;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_master_arbiter
// Description : Self-checking bench for i2c_master_arbiter with a simple
//               I2C master model and a round-robin/latency reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

  localparam int N = 4;
  localparam int T = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_rw = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   grant_out, done_out;
  logic           err_out, busy_out, m_enable_out, m_rw_out;
  logic [7:0]     rdata_out, m_data_out;
  logic [6:0]     m_addr_out;
  logic           m_ready = 1'b1;
  logic [7:0]     m_rdata = '0;

  int checks = 0;
  int errors = 0;

  // master model configuration for the next transaction
  int         cfg_d = 2;
  int         cfg_b = 20;
  logic [7:0] cfg_rd = '0;

  // reference model state
  int         ptr_m = 0;
  logic [7:0] exp_rdata = '0;

  i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .TO_W(11)) dut (
    .i2c_clock_in  (clk),
    .i2c_reset_n_in(rst_n),
    .req_in        (req),
    .req_rw_in     (req_rw),
    .req_addr_in   (req_addr),
    .req_data_in   (req_data),
    .grant_out     (grant_out),
    .done_out      (done_out),
    .err_out       (err_out),
    .rdata_out     (rdata_out),
    .busy_out      (busy_out),
    .m_enable_out  (m_enable_out),
    .m_rw_out      (m_rw_out),
    .m_addr_out    (m_addr_out),
    .m_data_out    (m_data_out),
    .m_ready_in    (m_ready),
    .m_rdata_in    (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first requested index at or after p, wrapping
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    req_rw[i]          = rw;
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = d;
    req[i]             = 1'b1;
  endtask

  // mode 0: keep req after done, 1: drop req at done, 2: drop req in WAIT_DONE
  task automatic run_txn(input int mode);
    int   idx, lat, en_cnt, exp_lat;
    bit   seen, dropped;
    logic exp_err;
    idx  = pick(req, ptr_m);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (grant_out != 0) begin seen = 1; break; end
    end
    chk("grant_seen", 32'(seen), 32'd1);
    chk("grant", 32'(grant_out), 32'(1 << idx));
    chk("m_addr", 32'(m_addr_out), 32'(req_addr[7*idx +: 7]));
    chk("m_data", 32'(m_data_out), 32'(req_data[8*idx +: 8]));
    chk("m_rw", 32'(m_rw_out), 32'(req_rw[idx]));
    chk("busy_in_txn", 32'(busy_out), 32'd1);
    exp_lat = 2 + cfg_d + cfg_b;
    exp_err = (exp_lat >= T);
    if (exp_err) exp_lat = T;
    lat = 0; en_cnt = 0; seen = 0; dropped = 0;
    for (int c = 0; c < T + 20; c++) begin
      @(negedge clk);
      lat++;
      if (m_enable_out) en_cnt++;
      if (done_out != 0) begin seen = 1; break; end
      if (mode == 2 && en_cnt > 0 && !m_enable_out && !dropped) begin
        req[idx] = 1'b0;
        dropped  = 1;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("enable_window", 32'(en_cnt), 32'(cfg_d + 1));
    chk("done", 32'(done_out), 32'(1 << idx));
    chk("err", 32'(err_out), 32'(exp_err));
    chk("enable_at_done", 32'(m_enable_out), 32'd0);
    chk("grant_at_done", 32'(grant_out), 32'd0);
    chk("busy_at_done", 32'(busy_out), 32'd0);
    if (!exp_err && req_rw[idx]) exp_rdata = cfg_rd;
    chk("rdata", 32'(rdata_out), 32'(exp_rdata));
    ptr_m = (idx + 1) % N;
    if (mode == 1) req[idx] = 1'b0;
  endtask

  // I2C master model: ready drops cfg_d cycles after enable, stays low cfg_b cycles
  initial begin
    int ph, cnt;
    ph = 0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || done_out != 0) begin
        ph = 0; m_ready = 1'b1;
      end else begin
        case (ph)
          0: if (m_enable_out) begin ph = 1; cnt = cfg_d; end
          1: begin
            cnt--;
            if (cnt == 0) begin m_ready = 1'b0; ph = 2; cnt = cfg_b; end
          end
          default: begin
            cnt--;
            if (cnt == 0) begin m_ready = 1'b1; m_rdata = cfg_rd; ph = 0; end
          end
        endcase
      end
    end
  end

  // Cycle invariants: one-hot grant/done, single-cycle done, stable fields
  initial begin
    logic [N-1:0] prev_done, prev_grant;
    logic [15:0]  held;
    prev_done = '0; prev_grant = '0; held = '0;
    forever begin
      @(negedge clk);
      chk("grant_onehot0", 32'($onehot0(grant_out)), 32'd1);
      chk("done_onehot0", 32'($onehot0(done_out)), 32'd1);
      if (prev_done != 0) chk("done_width", 32'(done_out), 32'd0);
      if (grant_out != 0 && prev_grant == grant_out)
        chk("fields_stable", 32'({m_rw_out, m_addr_out, m_data_out}), 32'(held));
      if (grant_out != 0 && prev_grant != grant_out)
        held = {m_rw_out, m_addr_out, m_data_out};
      prev_done  = done_out;
      prev_grant = grant_out;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit en_hi;
    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_rdata", 32'(rdata_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_mout", 32'({m_enable_out, m_rw_out, m_addr_out, m_data_out}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_grant", 32'(grant_out), 32'd0);
    chk("idle_busy", 32'(busy_out), 32'd0);

    // ---- single write from requester 0 ----
    set_req(0, 1'b0, 7'h50, 8'hA5);
    cfg_d = 2; cfg_b = 20;
    run_txn(1);

    // ---- read from requester 2 ----
    set_req(2, 1'b1, 7'h3C, 8'h00);
    cfg_d = 2; cfg_b = 15; cfg_rd = 8'h5E;
    run_txn(1);
    repeat (4) @(negedge clk);
    chk("rdata_held", 32'(rdata_out), 32'h5E);

    // ---- fairness: all requesters held ----
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
    for (int t = 0; t < 8; t++) begin
      cfg_d = $urandom_range(1, 4); cfg_b = $urandom_range(2, 30); cfg_rd = 8'($urandom);
      run_txn(0);
    end

    // ---- timeout: master never returns ready in time ----
    cfg_d = 2; cfg_b = 100;
    run_txn(0);
    for (int t = 0; t < N; t++) begin
      cfg_d = $urandom_range(1, 4); cfg_b = $urandom_range(2, 30); cfg_rd = 8'($urandom);
      run_txn(1);
    end

    // ---- requester 1 drops req in WAIT_DONE ----
    set_req(1, 1'b0, 7'h11, 8'h22);
    cfg_d = 1; cfg_b = 10;
    run_txn(2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_regrant", 32'(grant_out), 32'd0);
    end

    // ---- reset in WAIT_DONE ----
    set_req(3, 1'b0, 7'h33, 8'h44);
    set_req(0, 1'b1, 7'h0A, 8'h0B);
    cfg_d = 1; cfg_b = 40;
    en_hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (grant_out != 0) break;
    end
    chk("pre_rst_grant", 32'(grant_out), 32'(1 << pick(req, ptr_m)));
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_enable_out) en_hi = 1;
      else if (en_hi) break;
    end
    chk("reached_wait_done", 32'(en_hi && !m_enable_out && busy_out), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant_out), 32'd0);
    chk("arst_done", 32'(done_out), 32'd0);
    chk("arst_rdata", 32'(rdata_out), 32'd0);
    chk("arst_flags", 32'({err_out, busy_out}), 32'd0);
    chk("arst_mout", 32'({m_enable_out, m_rw_out, m_addr_out, m_data_out}), 32'd0);
    exp_rdata = '0;
    ptr_m     = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_done_in_rst", 32'(done_out), 32'd0);
    end
    rst_n = 1'b1;
    cfg_d = 2; cfg_b = 12; cfg_rd = 8'hC3;
    run_txn(1);
    cfg_d = 3; cfg_b = 8;
    run_txn(1);

    // ---- randomized traffic ----
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
      if (req == 0) set_req($urandom_range(0, N - 1), 1'($urandom), 7'($urandom), 8'($urandom));
      cfg_d  = $urandom_range(1, 4);
      cfg_b  = ($urandom_range(0, 7) == 0) ? 80 : $urandom_range(2, 40);
      cfg_rd = 8'($urandom);
      run_txn($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
